// File: rtl/exerciser_pkg.sv
// Shared encodings for the USB stream exerciser.
//   mode_e  : run-mode encoding of the 'mode' input, sampled on start
//   state_e : run state of the exerciser FSM
package exerciser_pkg;

  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,
    MODE_LOOP = 2'b01,
    MODE_GEN  = 2'b10,
    MODE_CHK  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOOP = 2'b01,
    GEN  = 2'b10,
    CHK  = 2'b11
  } state_e;

endpackage

// File: rtl/stream_buf.sv
// Small synchronous FIFO used as the loopback buffer.
//   clk, rst : clock, asynchronous active-low reset
//   push     : write din (caller guarantees count < DEPTH)
//   pop      : drop head (caller guarantees count > 0)
//   flush    : empty the buffer; wins over push/pop
//   din      : write data
//   head     : oldest entry, read from registered storage/pointer
//   count    : current occupancy, 0..DEPTH
module stream_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic [CW-1:0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // DEPTH is a power of two, so the pointers wrap for free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/usb_stream_exerciser.sv
// User-side traffic engine for the FT245 FIFO core: loopback, pattern
// generate and pattern check, with run statistics.
//   clk, rst              : user clock, asynchronous active-low reset
//   mode, start, abort    : run control (mode sampled on start)
//   gen_len               : words per GEN/CHK run, 0 = continuous
//   tx_ready/tx_write/tx_data : push side into the core TX FIFO
//   rx_valid/rx_read/rx_data  : show-ahead pop side of the core RX FIFO
//   busy, done            : run active / one-cycle completion pulse
//   word_count, err_count, first_err : run statistics
module usb_stream_exerciser
  import exerciser_pkg::*;
#(
  parameter int              DATA_W       = 32,
  parameter int              CNT_W        = 16,
  parameter logic [DATA_W-1:0] PATTERN_SEED = '0,
  parameter int              LOOP_DEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  gen_len,
  input  logic              tx_ready,
  output logic              tx_write,
  output logic [DATA_W-1:0] tx_data,
  input  logic              rx_valid,
  output logic              rx_read,
  input  logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       word_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [DATA_W-1:0] first_err
);

  localparam int                OCC_W   = $clog2(LOOP_DEPTH) + 1;
  localparam logic [OCC_W-1:0]  DEPTH_C = OCC_W'(LOOP_DEPTH);

  state_e             state, state_nxt;
  logic [DATA_W-1:0]  pattern;
  logic [DATA_W-1:0]  tx_hold;
  logic [DATA_W-1:0]  cur_word;
  logic [CNT_W-1:0]   len_q;
  logic [OCC_W-1:0]   occ;
  logic [DATA_W-1:0]  head;
  logic               tx_fire, rx_fire, cnt_inc, last_word, run_start, flush;
  logic [31:0]        wc_next;

  assign tx_fire   = tx_write & tx_ready;
  assign rx_fire   = rx_read & rx_valid;
  assign run_start = (state == IDLE) & start & (mode != MODE_NONE);
  assign busy      = (state != IDLE);
  assign flush     = busy & abort;
  // LOOP counts outgoing words, CHK counts incoming words.
  assign cnt_inc   = tx_fire | ((state == CHK) & rx_fire);
  assign wc_next   = word_count + 32'd1;
  assign last_word = cnt_inc & ((state == GEN) | (state == CHK)) &
                     (len_q != '0) & (wc_next == 32'(len_q));
  // Hold the last transmitted word while idle on the TX side.
  assign tx_data   = tx_write ? cur_word : tx_hold;

  // Strobes are masked during an abort cycle so no word is consumed
  // by a run that is being torn down (and then flushed).
  always_comb begin
    tx_write  = 1'b0;
    rx_read   = 1'b0;
    cur_word  = pattern;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (run_start) begin
          case (mode)
            MODE_LOOP: state_nxt = LOOP;
            MODE_GEN:  state_nxt = GEN;
            default:   state_nxt = CHK;
          endcase
        end
      end
      LOOP: begin
        rx_read  = rx_valid & (occ < DEPTH_C) & ~abort;
        tx_write = (occ != '0) & tx_ready & ~abort;
        cur_word = head;
      end
      GEN:     tx_write = tx_ready & ~abort;
      default: rx_read  = rx_valid & ~abort;
    endcase
    if (busy && (abort || last_word)) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      done       <= 1'b0;
      pattern    <= '0;
      tx_hold    <= '0;
      len_q      <= '0;
      word_count <= '0;
      err_count  <= '0;
      first_err  <= '0;
    end else begin
      state <= state_nxt;
      done  <= last_word;
      if (tx_write) tx_hold <= tx_data;
      if (run_start) begin
        pattern    <= PATTERN_SEED;
        len_q      <= gen_len;
        word_count <= '0;
        err_count  <= '0;
        first_err  <= '0;
      end else begin
        if (cnt_inc) word_count <= wc_next;
        if (state == GEN && tx_fire) pattern <= pattern + DATA_W'(1);
        if (state == CHK && rx_fire) begin
          if (rx_data == pattern) begin
            pattern <= pattern + DATA_W'(1);
          end else begin
            // Resync to the received stream so one slip costs one error.
            pattern <= rx_data + DATA_W'(1);
            if (err_count == '0) first_err <= rx_data;
            if (err_count != '1) err_count <= err_count + CNT_W'(1);
          end
        end
      end
    end
  end

  stream_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (LOOP_DEPTH),
    .CW     (OCC_W)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  ((state == LOOP) & rx_fire),
    .pop   ((state == LOOP) & tx_fire),
    .flush (flush),
    .din   (rx_data),
    .head  (head),
    .count (occ)
  );

endmodule

// File: tb/tb_usb_stream_exerciser.sv
// Scoreboard bench for usb_stream_exerciser: stimulus pushes expected TX
// words into a queue, a negedge monitor pops and compares on every TX
// transfer and checks the strobe protocol; directed checks cover stats.
module tb_usb_stream_exerciser;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [CNT_W-1:0]  gen_len = '0;
  logic              tx_ready = 1'b0;
  logic              tx_write;
  logic [DATA_W-1:0] tx_data;
  logic              rx_valid = 1'b0;
  logic              rx_read;
  logic [DATA_W-1:0] rx_data = '0;
  logic              busy, done;
  logic [31:0]       word_count;
  logic [CNT_W-1:0]  err_count;
  logic [DATA_W-1:0] first_err;

  usb_stream_exerciser dut (
    .clk(clk), .rst(rst), .mode(mode), .start(start), .abort(abort),
    .gen_len(gen_len), .tx_ready(tx_ready), .tx_write(tx_write),
    .tx_data(tx_data), .rx_valid(rx_valid), .rx_read(rx_read),
    .rx_data(rx_data), .busy(busy), .done(done), .word_count(word_count),
    .err_count(err_count), .first_err(first_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int done_seen = 0;
  int flood_pops = 0;
  int flood_target = 0;
  bit rx_flood = 1'b0;
  bit rx_fire_s;
  int d0;
  logic [DATA_W-1:0] exp_tx[$];
  logic [DATA_W-1:0] rx_src[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Main-thread inputs change 2 time units after posedge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic go(input logic [1:0] m, input logic [CNT_W-1:0] len);
    mode = m; gen_len = len; start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i = 0;
    while (busy && i < budget) begin cyc(1); i++; end
    chk(name, busy, 0);
  endtask

  // Monitor / scoreboard.
  initial forever begin
    @(negedge clk);
    if (done) done_seen++;
    if (rx_read) chk("rx_read_without_valid", rx_valid, 1);
    if (tx_write) begin
      chk("tx_write_without_ready", tx_ready, 1);
      if (tx_ready) begin
        if (exp_tx.size() == 0) begin
          n_assert++; n_fail++;
          $display("FAIL unexpected_tx_word: got 0x%0h, expected no transfer", tx_data);
        end else begin
          chk("tx_data", tx_data, exp_tx.pop_front());
        end
      end
    end
  end

  // RX source: show-ahead FIFO model, updated 1 unit after posedge.
  initial forever begin
    @(negedge clk);
    rx_fire_s = rx_valid && rx_read;
    @(posedge clk);
    #1;
    if (rx_fire_s) begin
      if (rx_flood) flood_pops++;
      else if (rx_src.size() > 0) void'(rx_src.pop_front());
    end
    if (rx_flood && flood_pops < flood_target) begin
      rx_valid = 1'b1; rx_data = 32'h5;
    end else if (rx_src.size() > 0) begin
      rx_valid = 1'b1; rx_data = rx_src[0];
    end else begin
      rx_valid = 1'b0;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    chk("rst_tx_write", tx_write, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_rx_read", rx_read, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_first_err", first_err, 0);
    cyc(2);
    rst = 1'b1;
    cyc(1);

    // Generate, gen_len=4, tx_ready=1: words on 4 consecutive cycles, done next
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_tx.push_back(32'(i));
    d0 = done_seen;
    go(2'b10, 16'd4);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("gen4_tx_write_c%0d", k), tx_write, (k <= 4) ? 1 : 0);
      chk($sformatf("gen4_done_c%0d", k), done, (k == 5) ? 1 : 0);
    end
    chk("gen4_busy_end", busy, 0);
    cyc(1);
    chk("gen4_word_count", word_count, 4);
    chk("gen4_done_pulses", done_seen - d0, 1);

    // Generate with tx_ready toggling
    for (int i = 0; i < 4; i++) exp_tx.push_back(32'(i));
    d0 = done_seen;
    go(2'b10, 16'd4);
    for (int i = 0; i < 40 && busy; i++) begin
      tx_ready = ~tx_ready;
      cyc(1);
    end
    tx_ready = 1'b0;
    chk("gentog_busy", busy, 0);
    cyc(1);
    chk("gentog_word_count", word_count, 4);
    chk("gentog_done_pulses", done_seen - d0, 1);
    chk("gentog_queue_empty", exp_tx.size(), 0);

    // Check: 0,1,2,7,8 -> one error, resync on 7
    rx_src.push_back(32'h0); rx_src.push_back(32'h1); rx_src.push_back(32'h2);
    rx_src.push_back(32'h7); rx_src.push_back(32'h8);
    cyc(2);
    d0 = done_seen;
    go(2'b11, 16'd5);
    wait_idle("chk_finish", 30);
    cyc(1);
    chk("chk_err_count", err_count, 1);
    chk("chk_first_err", first_err, 32'h7);
    chk("chk_word_count", word_count, 5);
    chk("chk_done_pulses", done_seen - d0, 1);
    chk("chk_rx_drained", rx_src.size(), 0);

    // Loopback: buffer fills at 2 while TX blocked, then drains in order
    tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      rx_src.push_back(32'hA5A5_0000 + 32'(i));
      exp_tx.push_back(32'hA5A5_0000 + 32'(i));
    end
    d0 = done_seen;
    go(2'b01, 16'd0);
    cyc(10);
    chk("loop_rx_stalled_after_2", rx_src.size(), 3);
    chk("loop_busy", busy, 1);
    tx_ready = 1'b1;
    for (int i = 0; i < 40 && word_count != 5; i++) cyc(1);
    chk("loop_word_count", word_count, 5);
    chk("loop_queue_empty", exp_tx.size(), 0);
    pulse_abort();
    cyc(1);
    chk("loop_abort_idle", busy, 0);
    chk("loop_abort_no_done", done_seen - d0, 0);

    // Abort mid-GEN after 2 words
    exp_tx.push_back(32'h0); exp_tx.push_back(32'h1);
    d0 = done_seen;
    go(2'b10, 16'd10);
    cyc(2);
    pulse_abort();
    cyc(1);
    chk("abort_gen_idle", busy, 0);
    chk("abort_gen_word_count", word_count, 2);
    chk("abort_gen_no_done", done_seen - d0, 0);
    chk("abort_gen_queue_empty", exp_tx.size(), 0);

    // Reset mid-LOOP with one word buffered
    tx_ready = 1'b0;
    rx_src.push_back(32'h1234_5678);
    cyc(1);
    go(2'b01, 16'd0);
    cyc(3);
    chk("rstloop_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    chk("rstloop_busy", busy, 0);
    chk("rstloop_tx_write", tx_write, 0);
    chk("rstloop_tx_data", tx_data, 0);
    chk("rstloop_rx_read", rx_read, 0);
    chk("rstloop_word_count", word_count, 0);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    tx_ready = 1'b1;
    go(2'b01, 16'd0);
    cyc(5);
    chk("rstloop_buffer_empty", word_count, 0);
    pulse_abort();
    tx_ready = 1'b0;

    // start with mode 00 ignored
    tx_ready = 1'b1;
    d0 = done_seen;
    go(2'b00, 16'd4);
    cyc(3);
    chk("mode00_busy", busy, 0);
    chk("mode00_no_done", done_seen - d0, 0);

    // start while busy ignored; gen_len sampled at start
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) exp_tx.push_back(32'(i));
    d0 = done_seen;
    go(2'b10, 16'd3);
    cyc(1);
    go(2'b11, 16'd1);
    tx_ready = 1'b1;
    wait_idle("busystart_finish", 20);
    cyc(1);
    chk("busystart_word_count", word_count, 3);
    chk("busystart_done_pulses", done_seen - d0, 1);
    chk("busystart_queue_empty", exp_tx.size(), 0);
    tx_ready = 1'b0;

    // err_count saturation with 65540 mismatching words
    flood_pops = 0;
    flood_target = 65540;
    rx_flood = 1'b1;
    cyc(2);
    go(2'b11, 16'd0);
    for (int i = 0; i < 70000 && flood_pops < flood_target; i++) cyc(1);
    cyc(2);
    chk("sat_err_count", err_count, 16'hFFFF);
    chk("sat_first_err", first_err, 32'h5);
    chk("sat_word_count", word_count, 65540);
    chk("sat_busy", busy, 1);
    pulse_abort();
    rx_flood = 1'b0;
    cyc(2);
    chk("final_idle", busy, 0);
    chk("final_queue_empty", exp_tx.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_stream_exerciser.md
Name: usb_stream_exerciser

Overview:
- User-side traffic engine for the FT245 FIFO core; connects to the core's tx_write/tx_data/tx_valid and rx_read/rx_valid/rx_data ports in the core's user clock domain.
- Three run modes:
  - loopback: RX words are buffered and returned on TX.
  - generate: an incrementing 32-bit pattern is written to TX.
  - check: RX words are verified against an incrementing pattern, with error statistics.
- Used for board bring-up and throughput/integrity measurement over USB.

Parameters:
- DATA_W, 32, data word width; matches the FT245 core bus.
- CNT_W, 16, width of gen_len and err_count.
- PATTERN_SEED, 32'h0000_0000, first word generated or expected after start.
- LOOP_DEPTH, 2, loopback buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  user clock; the FT245 core's tx_clk/rx_clk are tied to it.
- rst  in  1  reset, asynchronous, active-low.
- mode  in  2  run mode, sampled on start: 00 none, 01 loopback, 10 generate, 11 check.
- start  in  1  one-cycle pulse; begins a run.
- abort  in  1  one-cycle pulse; ends any run.
- gen_len  in  CNT_W  words per run for generate/check; 0 = continuous.
- tx_ready  in  1  core TX FIFO can accept a word (driven by the core's tx_valid).
- tx_write  out  1  push tx_data into the core.
- tx_data  out  DATA_W  TX word.
- rx_valid  in  1  core RX FIFO non-empty; rx_data is show-ahead (valid while rx_valid=1).
- rx_read  out  1  pop the current rx_data.
- rx_data  in  DATA_W  RX word.
- busy  out  1  a run is active.
- done  out  1  one-cycle pulse at run completion.
- word_count  out  32  words transferred in the current/last run; wraps.
- err_count  out  CNT_W  mismatches in check mode; saturates at all-ones.
- first_err  out  DATA_W  received value of the first mismatching word.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; loopback buffer empty; outputs at reset: tx_write=0, tx_data=0, rx_read=0, busy=0, done=0, word_count=0, err_count=0, first_err=0.
- Handshakes:
  - TX transfer = tx_write & tx_ready.
  - RX transfer = rx_read & rx_valid.
  - tx_write is never asserted while tx_ready=0; rx_read is never asserted while rx_valid=0.
- State IDLE:
  - start with mode 01/10/11 goes to LOOP/GEN/CHK next cycle.
  - On start: word_count, err_count and first_err are cleared; pattern register is loaded with PATTERN_SEED.
  - start with mode 00 is ignored.
- start while busy=1 is ignored.
- abort in any non-IDLE state: IDLE next cycle, buffer flushed, no done pulse.
- State LOOP:
  - rx_read = rx_valid & (occupancy < LOOP_DEPTH).
  - tx_write = (occupancy > 0) & tx_ready; tx_data = buffer head.
  - Simultaneous push and pop leaves occupancy unchanged.
  - word_count increments per TX transfer.
  - Exits only on abort.
- State GEN:
  - tx_write = tx_ready; tx_data = pattern.
  - Pattern increments by 1 (mod 2^32) per TX transfer; word_count increments per TX transfer.
  - When gen_len != 0 and the transfer completing word gen_len occurs: IDLE next cycle, done=1 for one cycle.
- State CHK:
  - rx_read = rx_valid.
  - Per RX transfer: compare rx_data against pattern.
    - Match: pattern increments.
    - Mismatch: err_count increments (saturating); first_err is captured only when err_count was 0; pattern resyncs to rx_data+1.
  - word_count increments per RX transfer.
  - Completion rule is the same as GEN.
- Loopback/GEN drive tx only; CHK drives rx only; the unused side's strobe is held 0.
- busy=1 in LOOP/GEN/CHK.
- tx_data holds its last value when tx_write=0.
- gen_len is sampled at start; changes mid-run have no effect.

Decomposition:
- Shared package exerciser_pkg:
  - mode encodings MODE_NONE/LOOP/GEN/CHK;
  - state enum IDLE/LOOP/GEN/CHK.
- One sub-module, stream_buf: LOOP_DEPTH-entry synchronous FIFO with count, push/pop, flush. Same clock and reset as the parent; outputs registered.
- Top holds the FSM, pattern register and statistics counters.

Test Plan:
- Generate, gen_len=4, tx_ready held 1: tx_data 0,1,2,3 on four consecutive cycles; done pulse one cycle after the last; word_count=4; busy returns to 0.
- Generate with tx_ready toggling 1,0,1,0...: tx_write is never high while tx_ready=0; still exactly 4 words, in order 0..3.
- Check with RX stream 0,1,2,7,8 and gen_len=5: err_count=1; first_err=32'h7; no further errors after resync; done pulse.
- Loopback:
  - RX 0xA5A5_0001..0005 with tx_ready=0 for 10 cycles: rx_read stops after 2 words.
  - After tx_ready=1: TX emits the 5 words in order; word_count=5.
- Abort mid-GEN after 2 words, then rst pulsed mid-LOOP with 1 word buffered:
  - abort: IDLE, no done pulse.
  - rst: all outputs 0 immediately (asynchronous); buffer empty after release.
- Edge cases:
  - Check with 65,540 mismatching words: err_count saturates at 16'hFFFF.
  - start with mode 00: no response.
  - start while busy: ignored.
